// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle RV32I controller.
package mc_pkg;

  localparam int unsigned OP_W    = 7;
  localparam int unsigned F3_W    = 3;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned ALUC_W  = 3;
  localparam int unsigned IMMS_W  = 3;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_EXECUTEU,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_ILLEGAL
  } state_t;

  // ALU operation class handed to the ALU decoder
  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_SUB,
    ALUOP_FUNCT
  } aluop_t;

  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;

  localparam logic [IMMS_W-1:0] IMM_I = 3'b000;
  localparam logic [IMMS_W-1:0] IMM_S = 3'b001;
  localparam logic [IMMS_W-1:0] IMM_B = 3'b010;
  localparam logic [IMMS_W-1:0] IMM_J = 3'b011;
  localparam logic [IMMS_W-1:0] IMM_U = 3'b100;

  localparam logic [ALUC_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUC_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALUC_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALUC_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALUC_W-1:0] ALU_XOR = 3'b100;
  localparam logic [ALUC_W-1:0] ALU_SLT = 3'b101;

  localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;
  localparam logic [SEL_W-1:0] SRCA_ZERO  = 2'b11;

  localparam logic [SEL_W-1:0] SRCB_RS2   = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b10;

  localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
  localparam logic [SEL_W-1:0] RES_DATA   = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALURES = 2'b10;

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// Maps the ALU operation class plus funct fields to an ALU control code.
module alu_decoder
  import mc_pkg::*;
(
  input  aluop_t             aluop,
  input  logic [F3_W-1:0]    funct3,
  input  logic               funct7b5,
  input  logic               op5,
  output logic [ALUC_W-1:0]  alucontrol
);

  // Class selects fixed add/sub; FUNCT class decodes funct3 (sub only for R-type)
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b100:  alucontrol = ALU_XOR;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback.
module mc_controller
  import mc_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    op,
  input  logic [F3_W-1:0]    funct3,
  input  logic               funct7b5,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pcwrite,
  output logic               adrsrc,
  output logic               memwrite,
  output logic               irwrite,
  output logic [SEL_W-1:0]   resultsrc,
  output logic [SEL_W-1:0]   alusrca,
  output logic [SEL_W-1:0]   alusrcb,
  output logic [ALUC_W-1:0]  alucontrol,
  output logic [IMMS_W-1:0]  immsrc,
  output logic               regwrite,
  output logic               retire,
  output logic               illegal
);

  // The controller only ever resets into FETCH
  if (RESET_STATE != S_FETCH) begin : g_bad_reset_state
    $error("mc_controller: RESET_STATE must be S_FETCH");
  end

  state_t state;
  state_t state_next;
  aluop_t aluop;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RESET_STATE;
    else        state <= state_next;
  end

  // Next state and datapath controls; enables are forced low while reset is held
  always_comb begin
    state_next = state;
    pcwrite    = 1'b0;
    adrsrc     = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    resultsrc  = RES_ALUOUT;
    alusrca    = SRCA_PC;
    alusrcb    = SRCB_RS2;
    aluop      = ALUOP_ADD;
    regwrite   = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;

    case (state)
      S_FETCH: begin
        alusrcb   = SRCB_FOUR;
        resultsrc = RES_ALURES;
        irwrite   = mem_ready;
        pcwrite   = mem_ready;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECUTER;
          OP_ITYPE:          state_next = S_EXECUTEI;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_LUI, OP_AUIPC:  state_next = S_EXECUTEU;
          default:           state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alusrca    = SRCA_RS1;
        alusrcb    = SRCB_IMM;
        state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adrsrc = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc  = RES_DATA;
        regwrite   = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        adrsrc   = 1'b1;
        memwrite = 1'b1;
        retire   = mem_ready;
        if (mem_ready) state_next = S_FETCH;
      end
      S_EXECUTER: begin
        alusrca    = SRCA_RS1;
        alusrcb    = SRCB_RS2;
        aluop      = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_EXECUTEI: begin
        alusrca    = SRCA_RS1;
        alusrcb    = SRCB_IMM;
        aluop      = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_EXECUTEU: begin
        alusrca    = op[5] ? SRCA_ZERO : SRCA_OLDPC;
        alusrcb    = SRCB_IMM;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        resultsrc  = RES_ALUOUT;
        regwrite   = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alusrca    = SRCA_RS1;
        alusrcb    = SRCB_RS2;
        aluop      = ALUOP_SUB;
        resultsrc  = RES_ALUOUT;
        retire     = 1'b1;
        case (funct3)
          3'b000:  pcwrite = zero;
          3'b001:  pcwrite = ~zero;
          default: pcwrite = 1'b0;
        endcase
        state_next = S_FETCH;
      end
      S_JAL: begin
        alusrca    = SRCA_OLDPC;
        alusrcb    = SRCB_FOUR;
        resultsrc  = RES_ALUOUT;
        pcwrite    = 1'b1;
        state_next = S_ALUWB;
      end
      S_ILLEGAL: begin
        illegal    = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase

    if (!rst_n) begin
      pcwrite  = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      retire   = 1'b0;
      illegal  = 1'b0;
    end
  end

  // Immediate format follows the opcode in every state
  always_comb begin
    case (op)
      OP_STORE:         immsrc = IMM_S;
      OP_BRANCH:        immsrc = IMM_B;
      OP_JAL:           immsrc = IMM_J;
      OP_LUI, OP_AUIPC: immsrc = IMM_U;
      default:          immsrc = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .op5        (op[5]),
    .alucontrol (alucontrol)
  );

endmodule
